// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port A arbiter: parameter defaults,
// requester index constants and the ownership FSM state type.
package ram_arb_pkg;

   localparam int DEF_ADDR_W  = 19;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_RD_LAT  = 2;
   localparam int DEF_LOCK_TO = 256;

   // Requester indices into the packed request vectors
   localparam int REQ_SEL = 0;   // selection writer
   localparam int REQ_CPU = 1;   // CPU

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ram_arb_rd_tag_pipe.sv
// Read tag pipeline: one one-hot requester tag per accepted read travels
// RD_LAT+1 stages. The last stage is the rvalid pulse; the stage before it
// tells the top when ram_q holds the data belonging to that tag.
// RD_LAT must be at least 1.
module ram_arb_rd_tag_pipe #(
   parameter int RD_LAT = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  logic [1:0] push_oh,
   output logic [1:0] rvalid,
   output logic       cap,
   output logic       busy
);

   logic [RD_LAT:0][1:0] tag_pipe;

   // Shift tags one stage per cycle; reset flushes every in-flight read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_pipe <= '0;
      end else begin
         tag_pipe[0] <= push ? push_oh : 2'b00;
         for (int k = 1; k <= RD_LAT; k++) begin
            tag_pipe[k] <= tag_pipe[k-1];
         end
      end
   end

   assign rvalid = tag_pipe[RD_LAT];
   assign cap    = |tag_pipe[RD_LAT-1];
   assign busy   = |tag_pipe;

endmodule

// File: rtl/ram_port_a_arbiter.sv
// Two-requester arbiter for RAM port A (0 = selection writer, 1 = CPU).
// Combinational grant, registered RAM drive, tagged read return, and a
// lock/ownership FSM with an idle timeout.
// Optional macro RAM_ARB_ROUND_ROBIN_EN: alternate grants on contention in
// IDLE instead of fixed priority to requester 0.
module ram_port_a_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RD_LAT  = DEF_RD_LAT,
   parameter int LOCK_TO = DEF_LOCK_TO
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [1:0]            lock,
   input  logic [2*ADDR_W-1:0]   addr,
   input  logic [2*DATA_W-1:0]   wdata,
   output logic [1:0]            gnt,
   output logic [1:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W-1:0]     ram_data,
   output logic                  ram_wren,
   input  logic [DATA_W-1:0]     ram_q,
   output logic                  busy,
   output logic                  lock_timeout
);

   localparam int CNT_W = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

   arb_state_t        state;
   logic [CNT_W-1:0]  idle_cnt;
   logic              eff_idle;
   logic              pick1;
   logic              acc;
   logic              win;
   logic              rd_cap;

   // Owner releasing its lock this cycle arbitrates as if already idle
   always_comb begin
      eff_idle = (state == IDLE) ||
                 (state == OWN0 && !lock[REQ_SEL]) ||
                 (state == OWN1 && !lock[REQ_CPU]);
   end

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic last_win;

   // On contention, favour the requester that did not win last time
   assign pick1 = ~last_win;

   // Remember the index of the most recent accepted access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last_win <= 1'b1;
      else if (acc) last_win <= win;
   end
`else
   assign pick1 = 1'b0;
`endif

   // Grant: contention resolved in idle, only the owner while locked
   always_comb begin
      gnt = 2'b00;
      if (eff_idle) begin
         if (req[REQ_SEL] && req[REQ_CPU]) gnt = pick1 ? 2'b10 : 2'b01;
         else                              gnt = req;
      end else if (state == OWN0) begin
         gnt[REQ_SEL] = req[REQ_SEL];
      end else begin
         gnt[REQ_CPU] = req[REQ_CPU];
      end
   end

   assign acc = |gnt;
   assign win = gnt[REQ_CPU];

   // Ownership FSM with idle counter and timeout pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         idle_cnt     <= '0;
         lock_timeout <= 1'b0;
      end else begin
         lock_timeout <= 1'b0;
         if (eff_idle) begin
            idle_cnt <= '0;
            if (acc && lock[win]) state <= win ? OWN1 : OWN0;
            else                  state <= IDLE;
         end else if (acc) begin
            idle_cnt <= '0;
         end else if (idle_cnt == CNT_W'(LOCK_TO - 1)) begin
            // Owner idle too long: force the lock free
            state        <= IDLE;
            idle_cnt     <= '0;
            lock_timeout <= 1'b1;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

   // Register the winning access onto RAM port A; hold bus when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_address <= '0;
         ram_data    <= '0;
         ram_wren    <= 1'b0;
      end else begin
         ram_wren <= 1'b0;
         if (acc) begin
            ram_address <= win ? addr[REQ_CPU*ADDR_W +: ADDR_W] : addr[REQ_SEL*ADDR_W +: ADDR_W];
            ram_data    <= win ? wdata[REQ_CPU*DATA_W +: DATA_W] : wdata[REQ_SEL*DATA_W +: DATA_W];
            ram_wren    <= we[win];
         end
      end
   end

   ram_arb_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (acc && !we[win]),
      .push_oh (gnt),
      .rvalid  (rvalid),
      .cap     (rd_cap),
      .busy    (busy)
   );

   // Capture ram_q the cycle before its tag emerges so rdata aligns with rvalid
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    rdata <= '0;
      else if (rd_cap) rdata <= ram_q;
   end

endmodule

// File: tb/tb_ram_port_a_arbiter.sv
// Self-checking bench for ram_port_a_arbiter (default parameters).
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
module tb_ram_port_a_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req = '0, we = '0, lock = '0;
   logic [37:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [1:0]  gnt, rvalid;
   logic [7:0]  rdata, ram_data, ram_q;
   logic [18:0] ram_address;
   logic        ram_wren, busy, lock_timeout;

   int n_chk = 0;
   int n_fail = 0;

   ram_port_a_arbiter dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we), .lock(lock),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_q(ram_q), .busy(busy), .lock_timeout(lock_timeout)
   );

   always #5 clk = ~clk;

   // RAM content as a fixed function of address
   function automatic logic [7:0] rd_fn(input logic [18:0] a);
      return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5A;
   endfunction

   // RAM port A model: address registered at port, data one cycle later (RD_LAT=2)
   always @(posedge clk) ram_q <= rd_fn(ram_address);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected RAM bus from the previous cycle's acceptance
   logic        pv_acc = 1'b0, pv_wren = 1'b0;
   logic [18:0] pv_addr = '0;
   logic [7:0]  pv_data = '0;

   // One cycle: check last cycle's RAM drive, apply inputs, check grant
   task automatic step(input string nm, input logic [1:0] r, input logic [1:0] w,
                       input logic [1:0] l, input logic [18:0] a0, input logic [18:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] eg);
      @(negedge clk);
      chk({nm, "_wren"}, 32'(ram_wren), 32'(pv_wren));
      if (pv_acc) begin
         chk({nm, "_addr"}, 32'(ram_address), 32'(pv_addr));
         chk({nm, "_data"}, 32'(ram_data), 32'(pv_data));
      end
      req = r; we = w; lock = l; addr = {a1, a0}; wdata = {d1, d0};
      #1;
      chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
      pv_acc  = |eg;
      pv_wren = eg[1] ? w[1] : (eg[0] ? w[0] : 1'b0);
      pv_addr = eg[1] ? a1 : a0;
      pv_data = eg[1] ? d1 : d0;
   endtask

   typedef struct {
      logic [1:0]  req, we;
      logic [18:0] a0, a1;
      logic [7:0]  d0, d1;
      logic [1:0]  egnt;
   } vec_t;

   vec_t       tv[9];
   logic [1:0] s_rv[32];
   logic [7:0] s_rd[32];
   logic       s_bz[32];
   logic [18:0] alt_a[4];
   int         bad;

   initial begin
      // Single-requester and no-request vectors, lock low throughout
      tv[0] = '{2'b01, 2'b00, 19'h00010, 19'h00000, 8'h00, 8'h00, 2'b01};
      tv[1] = '{2'b10, 2'b00, 19'h00000, 19'h12345, 8'h00, 8'h00, 2'b10};
      tv[2] = '{2'b00, 2'b00, 19'h11111, 19'h22222, 8'h12, 8'h34, 2'b00};
      tv[3] = '{2'b01, 2'b01, 19'h30E50, 19'h00000, 8'hA5, 8'h00, 2'b01};
      tv[4] = '{2'b10, 2'b10, 19'h00000, 19'h7FFFF, 8'h00, 8'h3C, 2'b10};
      tv[5] = '{2'b10, 2'b01, 19'h0AAAA, 19'h00001, 8'hFF, 8'h66, 2'b10};
      tv[6] = '{2'b01, 2'b00, 19'h40000, 19'h00000, 8'h5E, 8'h00, 2'b01};
      tv[7] = '{2'b00, 2'b11, 19'h00777, 19'h00888, 8'h01, 8'h02, 2'b00};
      tv[8] = '{2'b01, 2'b00, 19'h00000, 19'h7FFFF, 8'h00, 8'h00, 2'b01};
      for (int i = 0; i < 32; i++) begin
         s_rv[i] = 2'b00; s_rd[i] = 8'h00; s_bz[i] = 1'b0;
      end

      // Reset state
      #1;
      chk("rst_addr", 32'(ram_address), 32'h0);
      chk("rst_data", 32'(ram_data), 32'h0);
      chk("rst_wren", 32'(ram_wren), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_lto", 32'(lock_timeout), 32'h0);
      chk("rst_gnt", 32'(gnt), 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Contention in IDLE: requester 0 wins, read returns 3 cycles later
      step("r36", 2'b11, 2'b00, 2'b00, 19'h0ABCD, 19'h1F00F, 8'h00, 8'h00, 2'b01);
      step("r36_i1", 2'b00, 2'b00, 2'b00, 19'h0, 19'h0, 8'h0, 8'h0, 2'b00);
      chk("r36_busy1", 32'(busy), 32'h1);
      chk("r36_rv1", 32'(rvalid), 32'h0);
      step("r36_i2", 2'b00, 2'b00, 2'b00, 19'h0, 19'h0, 8'h0, 8'h0, 2'b00);
      chk("r36_rv2", 32'(rvalid), 32'h0);
      step("r36_i3", 2'b00, 2'b00, 2'b00, 19'h0, 19'h0, 8'h0, 8'h0, 2'b00);
      chk("r36_rv3", 32'(rvalid), 32'h1);
      chk("r36_rdata", 32'(rdata), 32'(rd_fn(19'h0ABCD)));
      step("r36_i4", 2'b00, 2'b00, 2'b00, 19'h0, 19'h0, 8'h0, 8'h0, 2'b00);
      chk("r36_rv4", 32'(rvalid), 32'h0);
      chk("r36_busy4", 32'(busy), 32'h0);

      // Vector table with a read-return scoreboard indexed by cycle
      for (int c = 0; c < 13; c++) begin
         if (c < 9) step("tbl", tv[c].req, tv[c].we, 2'b00, tv[c].a0, tv[c].a1,
                         tv[c].d0, tv[c].d1, tv[c].egnt);
         else       step("tbl_idle", 2'b00, 2'b00, 2'b00, 19'h0, 19'h0, 8'h0, 8'h0, 2'b00);
         chk("tbl_rvalid", 32'(rvalid), 32'(s_rv[c]));
         if (s_rv[c] != 2'b00) chk("tbl_rdata", 32'(rdata), 32'(s_rd[c]));
         chk("tbl_busy", 32'(busy), 32'(s_bz[c]));
         if (c < 9 && tv[c].egnt != 2'b00 && (tv[c].we & tv[c].egnt) == 2'b00) begin
            s_rv[c+3] = tv[c].egnt;
            s_rd[c+3] = rd_fn(tv[c].egnt[1] ? tv[c].a1 : tv[c].a0);
            for (int k = 1; k <= 3; k++) s_bz[c+k] = 1'b1;
         end
      end

      // Alternating back-to-back reads 0,1,0,1
      alt_a[0] = 19'h00100; alt_a[1] = 19'h00201; alt_a[2] = 19'h00302; alt_a[3] = 19'h00403;
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            if (c % 2 == 0) step("alt", 2'b01, 2'b00, 2'b00, alt_a[c], 19'h0, 8'h0, 8'h0, 2'b01);
            else            step("alt", 2'b10, 2'b00, 2'b00, 19'h0, alt_a[c], 8'h0, 8'h0, 2'b10);
         end else begin
            step("alt_idle", 2'b00, 2'b00, 2'b00, 19'h0, 19'h0, 8'h0, 8'h0, 2'b00);
         end
         if (c >= 3 && c <= 6) begin
            chk("alt_rvalid", 32'(rvalid), ((c - 3) % 2 == 0) ? 32'h1 : 32'h2);
            chk("alt_rdata", 32'(rdata), 32'(rd_fn(alt_a[c-3])));
         end else begin
            chk("alt_rvalid0", 32'(rvalid), 32'h0);
         end
      end

      // Locked 4-beat write by requester 0 with the CPU waiting
      step("lk_b0", 2'b11, 2'b01, 2'b01, 19'h30E50, 19'h00099, 8'h11, 8'h00, 2'b01);
      step("lk_b1", 2'b11, 2'b01, 2'b01, 19'h30E51, 19'h00099, 8'h22, 8'h00, 2'b01);
      step("lk_gap", 2'b10, 2'b00, 2'b01, 19'h30E51, 19'h00099, 8'h22, 8'h00, 2'b00);
      step("lk_b2", 2'b11, 2'b01, 2'b01, 19'h30E52, 19'h00099, 8'h33, 8'h00, 2'b01);
      step("lk_b3", 2'b11, 2'b01, 2'b01, 19'h30E53, 19'h00099, 8'h44, 8'h00, 2'b01);
      step("lk_drop", 2'b10, 2'b10, 2'b00, 19'h0, 19'h00055, 8'h0, 8'h99, 2'b10);
      step("lk_idle", 2'b00, 2'b00, 2'b00, 19'h0, 19'h0, 8'h0, 8'h0, 2'b00);

      // Lock timeout: owner idle for LOCK_TO cycles
      step("to_in", 2'b01, 2'b01, 2'b01, 19'h00200, 19'h0, 8'h42, 8'h0, 2'b01);
      bad = 0;
      for (int k = 1; k <= 256; k++) begin
         @(negedge clk);
         req = 2'b10; we = 2'b00; lock = 2'b01;
         #1;
         if (gnt !== 2'b00 || lock_timeout !== 1'b0) bad++;
      end
      chk("to_wait_bad", 32'(bad), 32'h0);
      pv_acc = 1'b0; pv_wren = 1'b0;
      step("to_rel", 2'b10, 2'b10, 2'b01, 19'h0, 19'h00300, 8'h0, 8'h77, 2'b10);
      chk("to_pulse", 32'(lock_timeout), 32'h1);
      step("to_after", 2'b00, 2'b00, 2'b00, 19'h0, 19'h0, 8'h0, 8'h0, 2'b00);
      chk("to_pulse_end", 32'(lock_timeout), 32'h0);

      // Sustained contention in IDLE
      for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
         step("cont", 2'b11, 2'b11, 2'b00, 19'(32'h01000 + k), 19'(32'h02000 + k),
              8'(k), 8'(k + 16), (k % 2 == 0) ? 2'b01 : 2'b10);
`else
         step("cont", 2'b11, 2'b11, 2'b00, 19'(32'h01000 + k), 19'(32'h02000 + k),
              8'(k), 8'(k + 16), 2'b01);
`endif
      end
      step("cont_idle", 2'b00, 2'b00, 2'b00, 19'h0, 19'h0, 8'h0, 8'h0, 2'b00);

      // Reset one cycle after a read acceptance flushes the read
      step("rs_rd", 2'b01, 2'b00, 2'b00, 19'h00400, 19'h0, 8'h0, 8'h0, 2'b01);
      @(negedge clk);
      reset_n = 1'b0; req = 2'b00;
      #1;
      chk("rs_busy_in", 32'(busy), 32'h0);
      chk("rs_addr_in", 32'(ram_address), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      pv_acc = 1'b0; pv_wren = 1'b0;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         if (rvalid !== 2'b00 || busy !== 1'b0 || ram_wren !== 1'b0) bad++;
      end
      chk("rs_after_bad", 32'(bad), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_a_arbiter.md
RAM_PORT_A_ARBITER -- requirements
Module: ram_port_a_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, RAM port A address width.
REQ-002 Parameter DATA_W, default 8, RAM port A data width.
REQ-003 Parameter RD_LAT, default 2, RAM cycles from address registered at port to ram_q valid.
REQ-004 Parameter LOCK_TO, default 256, owner-idle cycles before forced lock release.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  2  per-requester access request; index 0 = selection writer, index 1 = CPU.
REQ-008 we  in  2  per-requester write enable; 0 = read.
REQ-009 lock  in  2  per-requester ownership hold for multi-beat sequences.
REQ-010 addr  in  2xADDR_W  per-requester address, packed by index.
REQ-011 wdata  in  2xDATA_W  per-requester write data, packed by index.
REQ-012 gnt  out  2  access accepted this cycle (combinational).
REQ-013 rvalid  out  2  read data valid for the indexed requester (registered pulse).
REQ-014 rdata  out  DATA_W  read data, broadcast to both requesters.
REQ-015 ram_address / ram_data / ram_wren  out  ADDR_W / DATA_W / 1  registered RAM port A drive.
REQ-016 ram_q  in  DATA_W  RAM port A read data.
REQ-017 busy  out  1  at least one read in flight.
REQ-018 lock_timeout  out  1  one-cycle pulse on forced lock release.

Function
REQ-019 An access is accepted in the cycle req[i] and gnt[i] are both high; at most one gnt bit is high per cycle.
REQ-020 gnt[i] is low whenever req[i] is low.
REQ-021 In state IDLE with both requests high, fixed priority grants index 0.
REQ-022 An accepted access drives ram_address=addr[i], ram_data=wdata[i], ram_wren=we[i] on the next cycle; with no acceptance, ram_wren is 0 and ram_address/ram_data hold.
REQ-023 Accepted read from i pulses rvalid[i] exactly RD_LAT+1 cycles after the acceptance cycle, with rdata=ram_q in that cycle; back-to-back reads sustain one per cycle.
REQ-024 Writes never produce rvalid.
REQ-025 FSM states IDLE, OWN0, OWN1; IDLE->OWNi when an access from i is accepted with lock[i]=1.
REQ-026 In OWNi only requester i may be granted; the other requester waits with gnt low.
REQ-027 OWNi->IDLE in any cycle lock[i] is low; arbitration in that same cycle already follows IDLE rules.
REQ-028 In OWNi an idle counter increments each cycle req[i] is low and clears on acceptance; on reaching LOCK_TO-1 the FSM returns to IDLE and lock_timeout pulses for one cycle.
REQ-029 busy is high while any read tag is in the latency pipeline.

Reset
REQ-030 Reset values: ram_address=0, ram_data=0, ram_wren=0, rvalid=0, rdata=0, busy=0, lock_timeout=0, FSM=IDLE, idle counter=0, last-winner=1.
REQ-031 Reset asserted mid-operation flushes all in-flight read tags; no rvalid is produced for reads accepted before reset.

Configuration
REQ-032 Macro RAM_ARB_ROUND_ROBIN_EN defined: in IDLE with both requests high, the requester not recorded as last-winner is granted; last-winner updates on every acceptance.
REQ-033 Macro undefined: fixed priority per REQ-021; last-winner register is absent.

Structure
REQ-034 Package ram_arb_pkg holds ADDR_W/DATA_W/RD_LAT/LOCK_TO defaults, requester index constants REQ_SEL=0 and REQ_CPU=1, and enum arb_state_t {IDLE, OWN0, OWN1}.
REQ-035 Sub-module ram_arb_rd_tag_pipe implements the RD_LAT+1 deep valid+index shift register producing rvalid and busy.

Verification
REQ-036 req=2'b11, both reads, lock=0, IDLE -> gnt=2'b01; ram_address=addr[0] next cycle; rvalid=2'b01 3 cycles after acceptance (RD_LAT=2).
REQ-037 Requester 0 writes 4 bytes to 0x30E50..0x30E53 with lock[0]=1 while req[1]=1 -> gnt[1]=0 throughout; gnt[1]=1 in the cycle lock[0] drops.
REQ-038 OWN0 with req[0]=0 for 256 cycles -> lock_timeout single pulse at cycle 256, FSM IDLE, req[1] granted next cycle.
REQ-039 Alternating reads 0,1,0,1 back-to-back -> rvalid sequence 01,10,01,10 on consecutive cycles, rdata matches RAM model.
REQ-040 Reset asserted 1 cycle after a read acceptance -> no rvalid, busy=0, ram_wren=0 after release.
REQ-041 With RAM_ARB_ROUND_ROBIN_EN, req=2'b11 held 4 cycles -> gnt sequence 01,10,01,10.
